// File: rtl/dmux_pkg.sv
// dmux_pkg: select codes and one-hot helper shared by the 1-to-8 demux.
package dmux_pkg;
  localparam int SEL_W = 3;
  typedef enum logic [SEL_W-1:0] {
    SEL_A = 3'd0,
    SEL_B = 3'd1,
    SEL_C = 3'd2,
    SEL_D = 3'd3,
    SEL_E = 3'd4,
    SEL_F = 3'd5,
    SEL_G = 3'd6,
    SEL_H = 3'd7
  } sel_e;
  function automatic logic [7:0] onehot8(input logic [SEL_W-1:0] sel);
    return 8'b1 << sel;
  endfunction
endpackage

// File: rtl/dmux_8way_dec3to8.sv
// dec3to8: combinational 3-to-8 one-hot decoder; unknown selects decode to zero.
module dec3to8
  import dmux_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  output logic [7:0]       oh
);
  always_comb begin
    oh = '0;
    case (sel)
      SEL_A, SEL_B, SEL_C, SEL_D, SEL_E, SEL_F, SEL_G, SEL_H: oh = onehot8(sel);
      default: oh = '0;
    endcase
  end
endmodule

// File: rtl/dmux_8way.sv
// dmux_8way: steers din onto one of eight outputs a..h by {s1,s2,s3}; others are zero.
module dmux_8way
  import dmux_pkg::*;
#(
  parameter int WIDTH      = 1,
  parameter int REGISTERED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s1,
  input  logic             s2,
  input  logic             s3,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h
);
  logic [7:0]            oh;
  logic [7:0][WIDTH-1:0] out_d;
  logic [7:0][WIDTH-1:0] out;
  if (WIDTH < 1) begin : g_chk
    $error("dmux_8way: WIDTH must be >= 1");
  end
  dec3to8 u_dec (
    .sel({s1, s2, s3}),
    .oh (oh)
  );
  for (genvar i = 0; i < 8; i++) begin : g_and
    assign out_d[i] = {WIDTH{oh[i]}} & din;
  end
  if (REGISTERED != 0) begin : g_reg
    logic [7:0][WIDTH-1:0] out_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out_q <= '0;
      else        out_q <= out_d;
    end
    assign out = out_q;
  end else begin : g_comb
    assign out = out_d;
  end
  assign {h, g, f, e, d, c, b, a} = out;
endmodule

// File: tb/tb_dmux_8way.sv
// tb_dmux_8way: scoreboard bench for registered narrow/wide and combinational demux instances.
module tb_dmux_8way;
  typedef struct packed {
    logic [7:0]  e1;
    logic [63:0] e8;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic s1, s2, s3;
  logic din1;
  logic [7:0] din8;
  logic [7:0] o1;
  logic [7:0][7:0] o8;
  logic [7:0] oc;
  exp_t q[$];
  exp_t m;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmux_8way #(.WIDTH(1), .REGISTERED(1)) u_n (
    .clk(clk), .rst_n(rst_n), .s1(s1), .s2(s2), .s3(s3), .din(din1),
    .a(o1[0]), .b(o1[1]), .c(o1[2]), .d(o1[3]),
    .e(o1[4]), .f(o1[5]), .g(o1[6]), .h(o1[7])
  );
  dmux_8way #(.WIDTH(8), .REGISTERED(1)) u_w (
    .clk(clk), .rst_n(rst_n), .s1(s1), .s2(s2), .s3(s3), .din(din8),
    .a(o8[0]), .b(o8[1]), .c(o8[2]), .d(o8[3]),
    .e(o8[4]), .f(o8[5]), .g(o8[6]), .h(o8[7])
  );
  dmux_8way #(.WIDTH(1), .REGISTERED(0)) u_c (
    .clk(clk), .rst_n(rst_n), .s1(s1), .s2(s2), .s3(s3), .din(din1),
    .a(oc[0]), .b(oc[1]), .c(oc[2]), .d(oc[3]),
    .e(oc[4]), .f(oc[5]), .g(oc[6]), .h(oc[7])
  );

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [2:0] s, input logic d1, input logic [7:0] d8);
    exp_t r;
    r = '0;
    r.e1[s] = d1;
    r.e8[s*8 +: 8] = d8;
    return r;
  endfunction

  task automatic drive(input logic [2:0] s, input logic d1, input logic [7:0] d8);
    {s1, s2, s3} = s;
    din1 = d1;
    din8 = d8;
    q.push_back(model(s, d1, d8));
  endtask

  task automatic step(input logic [2:0] s, input logic d1, input logic [7:0] d8);
    @(negedge clk);
    drive(s, d1, d8);
  endtask

  task automatic pulse();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_n", {56'd0, o1}, 64'd0);
    chk("midrst_w", o8, 64'd0);
    rst_n = 1'b1;
    q.push_back(model({s1, s2, s3}, din1, din8));
    @(posedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      m = q.pop_front();
      chk("out_n", {56'd0, o1}, {56'd0, m.e1});
      chk("out_w", o8, m.e8);
    end
  end

  initial begin
    rst_n = 1'b0;
    {s1, s2, s3} = 3'b101;
    din1 = 1'b1;
    din8 = 8'hA5;
    #2;
    chk("rst0_n", {56'd0, o1}, 64'd0);
    chk("rst0_w", o8, 64'd0);
    @(posedge clk);
    #2;
    chk("rsthold_n", {56'd0, o1}, 64'd0);
    chk("rsthold_w", o8, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b101, 1'b1, 8'hA5);
    for (int i = 0; i < 8; i++) begin
      step(3'(i), 1'b1, 8'h11 << (i % 4));
      if (i == 3) pulse();
    end
    pulse();
    for (int i = 0; i < 8; i++) step(3'(i), 1'b0, 8'h00);
    step(3'b011, 1'b1, 8'hA5);
    step(3'b110, 1'b1, 8'hA5);
    step(3'b110, 1'b1, 8'h5A);
    step(3'b000, 1'b1, 8'hFF);
    step(3'b111, 1'b1, 8'h80);
    @(posedge clk);
    #2;
    chk("drain", 64'(q.size()), 64'd0);
    {s1, s2, s3} = 3'b010;
    din1 = 1'b1;
    #1;
    chk("comb_c", {56'd0, oc}, 64'h04);
    rst_n = 1'b0;
    #1;
    chk("comb_rst", {56'd0, oc}, 64'h04);
    rst_n = 1'b1;
    {s1, s2, s3} = 3'b111;
    din1 = 1'b0;
    #1;
    chk("comb_zero", {56'd0, oc}, 64'h00);
    din1 = 1'b1;
    #1;
    chk("comb_h", {56'd0, oc}, 64'h80);
    {s1, s2, s3} = 3'b001;
    #1;
    chk("comb_b", {56'd0, oc}, 64'h02);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
